vc_buffer: RTL and testbench

VC_BUFFER -- requirements
Module: vc_buffer

---
 rtl/vc_buffer_pkg.sv | 10 +
 rtl/vc_queue_ctrl.sv | 44 ++++
 rtl/vc_buffer.sv | 67 ++++++
 tb/tb_vc_buffer.sv | 109 ++++++++++
 4 files changed

// File: rtl/vc_buffer_pkg.sv
// vc_buffer_pkg: shared NoC constants for flit width and virtual-channel count
package vc_buffer_pkg;
  localparam int PAYLOAD_SIZE = 12;
  localparam int ADDR_SZ = 4;
  localparam int FLIT_W = PAYLOAD_SIZE + ADDR_SZ;
  localparam int NUM_VC_DEF = 2;
  function automatic int vc_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vc_queue_ctrl.sv
// vc_queue_ctrl: pointer, occupancy and flag tracking for one virtual channel
module vc_queue_ctrl #(
  parameter int DEPTH_LOG2 = 2,
  parameter int AFULL_LVL = (1 << DEPTH_LOG2) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_req,
  input  logic                  pop_req,
  output logic                  push_ok,
  output logic                  pop_ok,
  output logic [DEPTH_LOG2-1:0] wr_ptr,
  output logic [DEPTH_LOG2-1:0] rd_ptr,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
);
  typedef logic [DEPTH_LOG2:0] cnt_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  localparam cnt_t DEPTH_C = cnt_t'(1 << DEPTH_LOG2);
  localparam cnt_t AFULL_C = cnt_t'(AFULL_LVL);
  cnt_t count_nxt;
  assign push_ok = push_req & ~full;
  assign pop_ok = pop_req & ~empty;
  assign count_nxt = count + cnt_t'(push_ok) - cnt_t'(pop_ok);
  // flags are registered from next-state count so they are valid right after the edge
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= (AFULL_LVL == 0);
    end else begin
      wr_ptr <= wr_ptr + ptr_t'(push_ok);
      rd_ptr <= rd_ptr + ptr_t'(pop_ok);
      count <= count_nxt;
      full <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
      almost_full <= (count_nxt >= AFULL_C);
    end
endmodule

// File: rtl/vc_buffer.sv
// vc_buffer: per-VC circular flit queues with static storage and zero-latency head view
module vc_buffer
  import vc_buffer_pkg::*;
#(
  parameter int WIDTH = FLIT_W,
  parameter int DEPTH_LOG2 = 2,
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int AFULL_LVL = (1 << DEPTH_LOG2) - 1,
  localparam int VC_LOG2 = vc_bits(NUM_VC),
  localparam int CW = DEPTH_LOG2 + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic [VC_LOG2-1:0]   write_vc,
  input  logic [WIDTH-1:0]     item_in,
  input  logic                 read,
  input  logic [VC_LOG2-1:0]   read_vc,
  output logic [WIDTH-1:0]     item_out,
  output logic [NUM_VC-1:0]    full,
  output logic [NUM_VC-1:0]    empty,
  output logic [NUM_VC-1:0]    almost_full,
  output logic [NUM_VC*CW-1:0] count,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [WIDTH-1:0] mem [NUM_VC][DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr [NUM_VC];
  logic [DEPTH_LOG2-1:0] rd_ptr [NUM_VC];
  logic [NUM_VC-1:0] push_req, pop_req, push_ok, pop_ok;
  genvar k;
  generate
    for (k = 0; k < NUM_VC; k++) begin : g_vc
      assign push_req[k] = write && (write_vc == VC_LOG2'(k));
      assign pop_req[k] = read && (read_vc == VC_LOG2'(k));
      vc_queue_ctrl #(.DEPTH_LOG2(DEPTH_LOG2), .AFULL_LVL(AFULL_LVL)) u_ctrl (
        .clk(clk),
        .reset(reset),
        .push_req(push_req[k]),
        .pop_req(pop_req[k]),
        .push_ok(push_ok[k]),
        .pop_ok(pop_ok[k]),
        .wr_ptr(wr_ptr[k]),
        .rd_ptr(rd_ptr[k]),
        .count(count[k*CW +: CW]),
        .full(full[k]),
        .empty(empty[k]),
        .almost_full(almost_full[k])
      );
    end
  endgenerate
  assign item_out = mem[read_vc][rd_ptr[read_vc]];
  always_ff @(posedge clk)
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++)
        for (int i = 0; i < DEPTH; i++)
          mem[v][i] <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++)
        if (push_ok[v]) mem[v][wr_ptr[v]] <= item_in;
      overflow <= overflow | |(push_req & full);
      underflow <= underflow | |(pop_req & empty);
    end
endmodule

// File: tb/tb_vc_buffer.sv
// tb_vc_buffer: randomized and directed scoreboard bench against a queue-based model
module tb_vc_buffer;
  localparam int DEPTH = 4;
  localparam int AFL = DEPTH - 1;
  logic clk = 0;
  logic reset = 1;
  logic write = 0, read = 0;
  logic [0:0] write_vc = '0, read_vc = '0;
  logic [15:0] item_in = '0;
  logic [15:0] item_out;
  logic [1:0] full, empty, almost_full;
  logic [5:0] count;
  logic overflow, underflow;
  int checks = 0, errors = 0;
  logic [15:0] q [2][$];
  logic [15:0] exp_q [$];
  bit ovf = 0, udf = 0;

  vc_buffer dut (
    .clk(clk), .reset(reset), .write(write), .write_vc(write_vc), .item_in(item_in),
    .read(read), .read_vc(read_vc), .item_out(item_out), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("count[%0d]", k), int'(count[k*3 +: 3]), q[k].size());
      chk($sformatf("full[%0d]", k), int'(full[k]), int'(q[k].size() == DEPTH));
      chk($sformatf("empty[%0d]", k), int'(empty[k]), int'(q[k].size() == 0));
      chk($sformatf("almost_full[%0d]", k), int'(almost_full[k]), int'(q[k].size() >= AFL));
    end
    chk("overflow", int'(overflow), int'(ovf));
    chk("underflow", int'(underflow), int'(udf));
  endtask

  task automatic step(input bit w, input bit wv, input logic [15:0] d, input bit r, input bit rv, input bit rs = 0);
    bit pw, pr;
    write = w; write_vc = wv; item_in = d; read = r; read_vc = rv; reset = rs;
    pw = !rs && w && q[wv].size() < DEPTH;
    pr = !rs && r && q[rv].size() != 0;
    if (pr) exp_q.push_back(q[rv][0]);
    @(posedge clk);
    if (rs) begin
      q[0].delete(); q[1].delete(); ovf = 0; udf = 0;
    end else begin
      if (w && !pw) ovf = 1;
      if (r && !pr) udf = 1;
      if (pr) void'(q[rv].pop_front());
      if (pw) q[wv].push_back(d);
    end
    #1;
    check_state();
  endtask

  // monitor: every pop the DUT presents is matched against the scoreboard
  always @(negedge clk)
    if (!reset && read && !empty[read_vc]) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_unexpected: got item %0h with no expected pop", item_out);
      end else chk("item_out", int'(item_out), int'(exp_q.pop_front()));
    end

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 16'hA1 + 16'(i), 0, 0);
    step(1, 0, 16'hA5, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 16'h10, 0, 0);
    step(1, 1, 16'h20, 0, 0);
    step(1, 0, 16'h11, 0, 0);
    step(1, 1, 16'h21, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 16'hB0 + 16'(i), 0, 0);
    step(1, 1, 16'hBF, 1, 1);
    step(1, 0, 16'hC0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 16'h51, 0, 0);
    step(1, 0, 16'h52, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 16'h60 + 16'(i), 1, 0);
    step(1, 1, 16'h77, 1, 0, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 99) < 55), 1'($urandom), 16'($urandom), ($urandom_range(0, 99) < 45),
           1'($urandom), ($urandom_range(0, 299) == 0));
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1'(i));
    step(0, 0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
